// File: rtl/z80_daisy_irq_multi.sv
// Z80 mode-2 daisy-chain interrupt controller, NCH channels, fixed priority (ch0 highest).
// Build option IRQ_EDGE_EN: defined = edge-triggered request capture, undefined = level mode.
module z80_daisy_irq_multi #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [7:0]     DI,
  input  logic           M1_n,
  input  logic           IORQ_n,
  input  logic           RD_n,
  input  logic           IEI,
  output logic           IEO,
  output logic           INT_n,
  input  logic [7:0]     VEC_BASE,
  output logic [7:0]     VECT,
  output logic           VECTEN,
  input  logic [NCH-1:0] INTI,
  input  logic [NCH-1:0] INTEN,
  output logic [NCH-1:0] PEND,
  output logic [NCH-1:0] SRV
);

  typedef enum logic [1:0] {RETI_IDLE, RETI_CB_SEEN, RETI_ED_SEEN} reti_state_t;

  reti_state_t    r_reti_state, w_reti_next;
  logic           w_reti_clr;

  logic [NCH-1:0] r_pend, r_srv;
  logic           r_int_n;
  logic [7:0]     r_vect;
  logic           r_vecten;
  logic [CW-1:0]  r_cand;
  logic           r_cand_vld;
  logic           r_m1_win;
  logic           r_inta_d;
  logic           r_fetch_d;
  logic [7:0]     r_di;

  logic           w_inta, w_fetch, w_fetch_done, w_ack, w_any_elig, w_srv_seen;
  logic [NCH-1:0] w_elig, w_cand_oh, w_srv_lowest, w_pend_next, w_srv_next;
  logic [CW-1:0]  w_top;
  logic [7:0]     w_vec;

  assign w_inta       = ~M1_n & ~IORQ_n;
  assign w_fetch      = ~M1_n & ~RD_n;
  assign w_fetch_done = r_fetch_d & ~w_fetch;

  // A channel is blocked by any in-service channel of equal or higher priority.
  always_comb begin
    w_srv_seen = 1'b0;
    w_elig     = '0;
    w_top      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_srv_seen = w_srv_seen | r_srv[k];
      w_elig[k]  = r_pend[k] & ~w_srv_seen & IEI;
    end
    for (int unsigned k = NCH; k > 0; k--) begin
      if (w_elig[k-1]) w_top = CW'(k - 1);
    end
  end

  assign w_any_elig   = |w_elig;
  assign w_ack        = w_inta & ~r_inta_d & IEI & r_cand_vld;
  assign w_cand_oh    = NCH'(1) << r_cand;
  assign w_srv_lowest = r_srv & (~r_srv + NCH'(1));

  always_comb begin
    w_vec        = VEC_BASE;
    w_vec[CW:1]  = r_cand;
    w_vec[0]     = 1'b0;
  end

  // RETI decoder: bytes are consumed one cycle after their fetch ends.
  always_ff @(posedge CLK) begin
    if (RESET) r_reti_state <= RETI_IDLE;
    else       r_reti_state <= w_reti_next;
  end

  always_comb begin
    w_reti_next = r_reti_state;
    if (w_fetch_done) begin
      case (r_reti_state)
        RETI_IDLE: begin
          if (r_di == 8'hCB)      w_reti_next = RETI_CB_SEEN;
          else if (r_di == 8'hED) w_reti_next = RETI_ED_SEEN;
        end
        RETI_CB_SEEN: w_reti_next = RETI_IDLE;
        RETI_ED_SEEN: begin
          if (r_di == 8'hED) w_reti_next = RETI_ED_SEEN;
          else               w_reti_next = RETI_IDLE;
        end
        default: w_reti_next = RETI_IDLE;
      endcase
    end
  end

  always_comb begin
    w_reti_clr = w_fetch_done & (r_reti_state == RETI_ED_SEEN) & (r_di == 8'h4D) & IEI;
  end

`ifdef IRQ_EDGE_EN
  logic [NCH-1:0] r_inti_d;

  always_ff @(posedge CLK) begin
    if (RESET) r_inti_d <= '0;
    else       r_inti_d <= INTI;
  end

  assign w_pend_next = (r_pend | (INTI & ~r_inti_d)) & INTEN & ~(w_ack ? w_cand_oh : '0);
`else
  assign w_pend_next = INTI & INTEN;
`endif

  assign w_srv_next = (r_srv & ~(w_reti_clr ? w_srv_lowest : '0)) | (w_ack ? w_cand_oh : '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pend     <= '0;
      r_srv      <= '0;
      r_int_n    <= 1'b1;
      r_vect     <= '0;
      r_vecten   <= 1'b0;
      r_cand     <= '0;
      r_cand_vld <= 1'b0;
      r_m1_win   <= 1'b0;
      r_inta_d   <= 1'b0;
      r_fetch_d  <= 1'b0;
      r_di       <= '0;
    end else begin
      r_pend    <= w_pend_next;
      r_srv     <= w_srv_next;
      r_int_n   <= ~w_any_elig;
      r_inta_d  <= w_inta;
      r_fetch_d <= w_fetch;
      if (w_fetch) r_di <= DI;
      // Candidate is frozen at the start of M1 and held for the whole M1 window.
      if (M1_n) begin
        r_m1_win   <= 1'b0;
        r_cand_vld <= 1'b0;
      end else if (!r_m1_win && IORQ_n) begin
        r_m1_win   <= 1'b1;
        r_cand     <= w_top;
        r_cand_vld <= w_any_elig;
      end
      if (w_ack) begin
        r_vect   <= w_vec;
        r_vecten <= 1'b1;
      end else if (!w_inta) begin
        r_vecten <= 1'b0;
      end
    end
  end

  assign IEO    = IEI & ~|r_srv & ~(r_m1_win & r_cand_vld)
                & ~(|r_pend & M1_n & (r_reti_state != RETI_ED_SEEN));
  assign INT_n  = r_int_n;
  assign VECT   = r_vect;
  assign VECTEN = r_vecten;
  assign PEND   = r_pend;
  assign SRV    = r_srv;

endmodule

// File: tb/tb_z80_daisy_irq_multi.sv
// Randomized bench for z80_daisy_irq_multi with a cycle-level reference model of the Z80 daisy chain.
module tb_z80_daisy_irq_multi;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 2;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [7:0]     DI;
  logic           M1_n, IORQ_n, RD_n, IEI;
  logic           IEO, INT_n;
  logic [7:0]     VEC_BASE, VECT;
  logic           VECTEN;
  logic [NCH-1:0] INTI, INTEN, PEND, SRV;

  int n_checks = 0;
  int n_errors = 0;

  z80_daisy_irq_multi #(.NCH(NCH), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .DI(DI), .M1_n(M1_n), .IORQ_n(IORQ_n), .RD_n(RD_n),
    .IEI(IEI), .IEO(IEO), .INT_n(INT_n), .VEC_BASE(VEC_BASE), .VECT(VECT),
    .VECTEN(VECTEN), .INTI(INTI), .INTEN(INTEN), .PEND(PEND), .SRV(SRV)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [3:0] m_pend, m_srv, m_inti_prev;
  bit         m_int_n, m_vecten, m_cvld, m_win, m_inta_prev, m_fetch_prev;
  logic [7:0] m_vect, m_last_op, m_prefix;
  int         m_cand;
  logic [7:0] seen_vect;
  bit         seen_vecten;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_step();
    bit inta, fetch, ack;
    int first;
    logic [3:0] np, ns;
    if (RESET) begin
      m_pend = '0; m_srv = '0; m_inti_prev = '0; m_int_n = 1; m_vecten = 0;
      m_vect = '0; m_cvld = 0; m_win = 0; m_cand = 0; m_inta_prev = 0;
      m_fetch_prev = 0; m_prefix = 8'h00; m_last_op = 8'h00;
      return;
    end
    inta  = !M1_n && !IORQ_n;
    fetch = !M1_n && !RD_n;
    // Highest priority request with no service at or above its level.
    first = -1;
    for (int c = 0; c < 4; c++)
      if (first < 0 && IEI && m_pend[c] && (m_srv & ((1 << (c + 1)) - 1)) == 0) first = c;
    ack = inta && !m_inta_prev && IEI && m_cvld;
`ifdef IRQ_EDGE_EN
    np = (m_pend | (INTI & ~m_inti_prev)) & INTEN;
    if (ack) np[m_cand] = 1'b0;
`else
    np = INTI & INTEN;
`endif
    ns = m_srv;
    if (m_fetch_prev && !fetch) begin
      if (m_prefix == 8'hED && m_last_op == 8'h4D && IEI) begin
        for (int c = 0; c < 4; c++)
          if (ns[c]) begin ns[c] = 1'b0; break; end
      end
      if (m_prefix == 8'hCB)                           m_prefix = 8'h00;
      else if (m_last_op == 8'hED)                     m_prefix = 8'hED;
      else if (m_last_op == 8'hCB && m_prefix == 8'h00) m_prefix = 8'hCB;
      else                                             m_prefix = 8'h00;
    end
    if (ack) begin
      ns[m_cand] = 1'b1;
      m_vect     = (VEC_BASE & 8'hF8) | 8'(m_cand * 2);
      m_vecten   = 1;
    end else if (!inta) begin
      m_vecten = 0;
    end
    if (M1_n) begin
      m_win = 0; m_cvld = 0;
    end else if (!m_win && IORQ_n) begin
      m_win = 1; m_cvld = (first >= 0); m_cand = (first >= 0) ? first : 0;
    end
    m_int_n = (first < 0);
    m_pend = np; m_srv = ns; m_inti_prev = INTI;
    m_inta_prev = inta; m_fetch_prev = fetch;
    if (fetch) m_last_op = DI;
  endtask

  task automatic tick();
    bit ieo;
    @(posedge CLK);
    mdl_step();
    #1;
    ieo = IEI && (m_srv == 0) && !(m_win && m_cvld) && !((m_pend != 0) && M1_n && m_prefix != 8'hED);
    check("INT_n", INT_n, m_int_n);
    check("PEND", PEND, m_pend);
    check("SRV", SRV, m_srv);
    check("VECTEN", VECTEN, m_vecten);
    check("VECT", VECT, m_vect);
    check("IEO", IEO, ieo);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fetch(input logic [7:0] b);
    M1_n = 0; RD_n = 0; DI = b;
    tick(); tick();
    M1_n = 1; RD_n = 1; DI = 8'($urandom);
    tick();
  endtask

  task automatic reti();
    fetch(8'hED);
    fetch(8'h4D);
  endtask

  task automatic inta();
    M1_n = 0;
    tick(); tick();
    IORQ_n = 0;
    tick();
    seen_vect = VECT; seen_vecten = VECTEN;
    tick();
    M1_n = 1; IORQ_n = 1;
    tick();
  endtask

  task automatic rand_idle();
    INTI  = 4'($urandom);
    INTEN = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
    IEI   = ($urandom_range(0, 9) != 0);
    tick();
  endtask

  initial begin
    RESET = 1; DI = 0; M1_n = 1; IORQ_n = 1; RD_n = 1; IEI = 1;
    VEC_BASE = 8'h40; INTI = 0; INTEN = 4'hF;
    tick(); tick();
    check("rst_int_n", INT_n, 1);
    check("rst_vecten", VECTEN, 0);
    RESET = 0;
    tick();

    // Single request, acknowledge, RETI
    INTI = 4'b0100; tick(); tick();
    check("t1_int_n", INT_n, 0);
    inta();
    check("t1_vect", seen_vect, 8'h44);
    check("t1_vecten", seen_vecten, 1);
    INTI = 0; idle(2);
    check("t1_srv", SRV, 4'b0100);
    check("t1_pend", PEND, 0);
    reti();
    check("t1_srv_reti", SRV, 0);
    tick();
    check("t1_int_n_end", INT_n, 1);

    // Simultaneous requests: priority, masking of the lower one
    INTI = 4'b1010; tick(); tick();
    inta();
    check("t2_vect", seen_vect, 8'h42);
    check("t2_srv", SRV, 4'b0010);
    INTI = 4'b1000; idle(3);
    check("t2_masked", INT_n, 1);
    reti(); idle(2);
    check("t2_int_n", INT_n, 0);
    inta();
    check("t2_vect3", seen_vect, 8'h46);
    INTI = 0; idle(1); reti();

    // Nesting
    INTI = 4'b0100; idle(2); inta(); INTI = 0; idle(1);
    INTI = 4'b0001; idle(2);
    check("t3_int_n", INT_n, 0);
    inta();
    check("t3_vect", seen_vect, 8'h40);
    check("t3_srv", SRV, 4'b0101);
    INTI = 0; idle(1);
    reti(); check("t3_reti1", SRV, 4'b0100);
    reti(); check("t3_reti2", SRV, 0);

    // IEI low blocks everything
    IEI = 0; INTI = 4'b0001; idle(3);
    check("t4_int_n", INT_n, 1);
    check("t4_ieo", IEO, 0);
    inta();
    check("t4_vecten", seen_vecten, 0);
    INTI = 0; IEI = 1; idle(2);

    // CB prefix swallows the following ED
    INTI = 4'b0001; idle(2); inta(); INTI = 0; idle(1);
    fetch(8'hCB); fetch(8'hED); fetch(8'h4D);
    check("t5_srv", SRV, 4'b0001);
    reti();

    // Reset in the middle of INTA
    INTI = 4'b0010; idle(2);
    M1_n = 0; tick(); tick();
    IORQ_n = 0; tick();
    check("t6_vecten", VECTEN, 1);
    RESET = 1; tick();
    check("t6_vecten_rst", VECTEN, 0);
    check("t6_srv_rst", SRV, 0);
    check("t6_ieo", IEO, 1);
    RESET = 0; M1_n = 1; IORQ_n = 1; INTI = 0;
    tick();

    // Randomized bus traffic
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: rand_idle();
        3:       fetch(($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'hCB);
        4:       fetch(8'hED);
        5:       fetch(8'h4D);
        6, 7:    inta();
        8:       reti();
        default: begin
          if ($urandom_range(0, 7) == 0) begin
            RESET = 1; tick(); RESET = 0;
          end else begin
            VEC_BASE = 8'($urandom);
            M1_n = 0; tick();
            INTI = 4'($urandom); tick();
            IORQ_n = 0; tick(); tick();
            M1_n = 1; IORQ_n = 1; tick();
          end
        end
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
